gcd_requester: RTL and testbench
================================

// Module: gcd_requester
// PURPOSE
//   Initiator side of the start/ack GCD handshake. Buffers operand pairs from
//   upstream, drives a GCD responder (start, a, b) with a four-phase handshake,
//   captures its result on ack and presents it downstream with valid/ready.
//   Sits between a producer of operand pairs and one GCD engine.
// PARAMETERS
//   W        8    operand/result width in bits
//   DEPTH    4    operand FIFO entries (power of two, >=2)
//   TIMEOUT  255  max cycles waiting for each ack edge before abort (>=1)
// PORTS
//   Clk        in   1      single clock, all logic on posedge
//   Rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand pair offered
//   in_ready   out  1      FIFO not full; pair accepted when in_valid&in_ready
//   in_a       in   W      operand a
//   in_b       in   W      operand b
//   start      out  1      request to responder
//   a          out  W      operand a to responder, stable while start=1
//   b          out  W      operand b to responder, stable while start=1
//   y          in   W      result from responder, sampled when ack=1
//   ack        in   1      responder done / still holding result
//   res_valid  out  1      result available
//   res_ready  in   1      downstream accepts result
//   res_data   out  W      GCD result (0 on error)
//   res_err    out  1      result aborted by timeout, qualified by res_valid
//   busy       out  1      FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//   Reset: start=0, a=b=0, res_valid=0, res_err=0, res_data=0, FIFO empty,
//     in_ready=1, busy=0, timer=0, FSM=IDLE. Reset mid-handshake drops start
//     the next edge; in-flight and queued pairs are discarded.
//   FIFO: push on in_valid&in_ready, pop when FSM leaves IDLE with a pair.
//     Full: in_ready=0. Simultaneous push+pop when full is not allowed (ready
//     is registered-full based). Pointers wrap modulo DEPTH.
//   FSM states:
//     IDLE  : FIFO non-empty and res_valid=0 -> pop head. If a==0 or b==0:
//             res_data=a|b, res_valid=1, no handshake (responder would never
//             terminate), stay IDLE. Else load a,b, start=1, timer=0 -> REQ.
//     REQ   : start=1. ack=1 -> capture y into res_data, res_valid=1,
//             start=0, timer=0 -> REL. timer==TIMEOUT -> res_err=1,
//             res_data=0, res_valid=1, start=0 -> REL.
//     REL   : start=0, wait ack=0 -> IDLE. timer==TIMEOUT -> res_err=1 is
//             held on the next result; FSM -> IDLE regardless.
//   Latency: start rises 1 cycle after pop decision; res_valid rises on the
//     edge that samples ack=1; next start no earlier than 1 cycle after ack=0.
//   Output: res_valid held with res_data/res_err stable until
//     res_valid&res_ready; IDLE does not issue a new request while res_valid=1
//     (single-entry output, backpressure stalls the FSM, not the FIFO).
//   a/b hold last values after start falls; responder ignores them.
//   ack=1 seen while in IDLE (stale) is ignored; start is not raised until
//     ack=0.
//   Timer width $clog2(TIMEOUT+1); saturates, never wraps.
// STRUCTURE
//   Package gcd_pkg: state encoding (IDLE/REQ/REL localparams), default W,
//     function is_trivial(a,b).
//   Sub-module gcd_req_fifo (W*2 wide, DEPTH deep, sync, full/empty flags).
//   FSM, timer, output register in the top module.
// TESTING
//   Pair (10,24), model responder -> start held until ack, res_data=2, err=0.
//   Pairs (10,24),(11,33),(9,6) back-to-back, res_ready=1 -> results 2,11,3
//     in order, start low >=1 cycle between requests.
//   Pair (0,7) -> res_data=7 with no start pulse; (0,0) -> res_data=0.
//   Fill FIFO with DEPTH+1 pairs, res_ready=0 -> in_ready=0 after DEPTH,
//     one result held stable; release -> all DEPTH+1 results, none lost.
//   Responder never acks, TIMEOUT=15 -> res_err=1, res_data=0 at cycle 16
//     after start, start dropped, next pair proceeds normally.
//   Rst asserted while in REQ -> start=0, res_valid=0, busy=0 next cycle.

Source files
------------

// File: rtl/gcd_pkg.sv
// ============================================================================
//  Module   : gcd_pkg
//  Purpose  : Shared definitions for the GCD requester: FSM state encoding,
//             default operand width and the trivial-operand predicate.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package gcd_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    // A zero operand makes the subtractive responder spin forever, so such
    // pairs are answered locally (gcd(x,0) = x).
    function automatic logic is_trivial(input logic [31:0] a, input logic [31:0] b);
        return (a == 32'd0) || (b == 32'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gcd_req_fifo.sv
// ============================================================================
//  Module   : gcd_req_fifo
//  Purpose  : Synchronous single-clock FIFO holding operand pairs.
//  Ports    : clk, rst        clock / synchronous active-high reset
//             push, wdata     write strobe and data (ignored when full)
//             pop, rdata      read strobe and head-of-queue data (show-ahead)
//             full, empty     status flags derived from registered pointers
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gcd_req_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the
    // index bits are equal.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop  && !empty;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gcd_requester.sv
// ============================================================================
//  Module   : gcd_requester
//  Purpose  : Initiator side of a four-phase start/ack GCD handshake. Queues
//             operand pairs, drives one GCD responder, and presents each
//             result downstream through a single-entry valid/ready register.
//  Ports    : clk, rst                      clock / sync active-high reset
//             in_valid, in_ready, in_a, in_b  upstream operand pairs
//             start, a, b, y, ack             responder handshake
//             res_valid, res_ready,           downstream result
//             res_data, res_err
//             busy                            queue non-empty or FSM active
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gcd_requester
    import gcd_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         start,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    input  logic [W-1:0] y,
    input  logic         ack,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_err,
    output logic         busy
);

    localparam int            TW          = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] C_TIMER_MAX = TW'(TIMEOUT);

    // ------------------------------------------------------------------
    // Operand queue
    // ------------------------------------------------------------------
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic           w_pop;
    logic [2*W-1:0] w_head;
    logic [W-1:0]   w_head_a;
    logic [W-1:0]   w_head_b;
    logic           w_head_trivial;

    gcd_req_fifo #(
        .WIDTH (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .wdata ({in_a, in_b}),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_head_a       = w_head[2*W-1:W];
    assign w_head_b       = w_head[W-1:0];
    assign w_head_trivial = is_trivial(32'(w_head_a), 32'(w_head_b));

    // ------------------------------------------------------------------
    // FSM, timer and output register
    // ------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_next;
    logic          r_start,     w_start;
    logic [W-1:0]  r_a,         w_a;
    logic [W-1:0]  r_b,         w_b;
    logic          r_res_valid, w_res_valid;
    logic [W-1:0]  r_res_data,  w_res_data;
    logic          r_res_err,   w_res_err;
    // Set when the responder never released ack; reported on the next result.
    logic          r_err_pend,  w_err_pend;
    logic [TW-1:0] r_timer,     w_timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_start     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_err_pend  <= 1'b0;
            r_timer     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_start     <= w_start;
            r_a         <= w_a;
            r_b         <= w_b;
            r_res_valid <= w_res_valid;
            r_res_data  <= w_res_data;
            r_res_err   <= w_res_err;
            r_err_pend  <= w_err_pend;
            r_timer     <= w_timer;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = r_start;
        w_a          = r_a;
        w_b          = r_b;
        w_res_valid  = r_res_valid;
        w_res_data   = r_res_data;
        w_res_err    = r_res_err;
        w_err_pend   = r_err_pend;
        w_timer      = r_timer;
        w_pop        = 1'b0;

        if (r_res_valid && res_ready) begin
            w_res_valid = 1'b0;
        end

        case (r_state)
            IDLE: begin
                // The output register is single-entry: a held result stalls
                // the FSM while the queue keeps accepting pairs.
                if (!w_fifo_empty && !r_res_valid) begin
                    if (w_head_trivial) begin
                        w_pop       = 1'b1;
                        w_res_valid = 1'b1;
                        w_res_data  = w_head_a | w_head_b;
                        w_res_err   = r_err_pend;
                        w_err_pend  = 1'b0;
                    end else if (!ack) begin
                        // A stale ack must fall before a new request starts.
                        w_pop        = 1'b1;
                        w_a          = w_head_a;
                        w_b          = w_head_b;
                        w_start      = 1'b1;
                        w_timer      = '0;
                        w_state_next = REQ;
                    end
                end
            end

            REQ: begin
                if (ack) begin
                    w_res_valid  = 1'b1;
                    w_res_data   = y;
                    w_res_err    = r_err_pend;
                    w_err_pend   = 1'b0;
                    w_start      = 1'b0;
                    w_timer      = '0;
                    w_state_next = REL;
                end else if (r_timer == C_TIMER_MAX) begin
                    w_res_valid  = 1'b1;
                    w_res_data   = '0;
                    w_res_err    = 1'b1;
                    w_err_pend   = 1'b0;
                    w_start      = 1'b0;
                    w_timer      = '0;
                    w_state_next = REL;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end

            REL: begin
                if (!ack) begin
                    w_state_next = IDLE;
                end else if (r_timer == C_TIMER_MAX) begin
                    w_err_pend   = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end

            default: begin
                w_start      = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = !w_fifo_full;
    assign start     = r_start;
    assign a         = r_a;
    assign b         = r_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;
    assign busy      = !w_fifo_empty || (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_gcd_requester.sv
// ============================================================================
//  Module   : tb_gcd_requester
//  Purpose  : Directed self-checking bench for gcd_requester with a
//             behavioural GCD responder (acks a few cycles after start).
//  Ports    : none (top-level bench)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gcd_requester;

    localparam int W       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         ack;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_err;
    logic         busy;

    int checks = 0;
    int errors = 0;

    gcd_requester #(
        .W       (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .start     (start),
        .a         (a),
        .b         (b),
        .y         (y),
        .ack       (ack),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural responder: raises ack three cycles into a request with
    // the GCD of the presented operands, drops it once start falls.
    // ------------------------------------------------------------------
    logic resp_en;
    int   resp_dly;

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] x, input logic [W-1:0] z);
        logic [W-1:0] p;
        logic [W-1:0] q;
        logic [W-1:0] t;
        p = x;
        q = z;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    initial begin
        ack      = 1'b0;
        y        = '0;
        resp_dly = 0;
    end

    always @(posedge clk) begin
        if (!start) begin
            resp_dly <= 0;
            if (ack) ack <= 1'b0;
        end else if (resp_en && !ack) begin
            if (resp_dly == 2) begin
                ack <= 1'b1;
                y   <= gcd_f(a, b);
            end else begin
                resp_dly <= resp_dly + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol monitor sampled on the falling edge
    // ------------------------------------------------------------------
    logic         prev_start = 1'b0;
    logic         prev_ack   = 1'b0;
    logic [W-1:0] prev_a     = '0;
    logic [W-1:0] prev_b     = '0;
    int           rises      = 0;
    int           stale_viol = 0;
    int           early_drop = 0;
    int           ab_viol    = 0;
    logic [W-1:0] rise_a     = '0;
    logic [W-1:0] rise_b     = '0;

    always @(negedge clk) begin
        if (start && !prev_start) begin
            rises  <= rises + 1;
            rise_a <= a;
            rise_b <= b;
            if (prev_ack) stale_viol <= stale_viol + 1;
        end
        if (!start && prev_start && !prev_ack && !rst) early_drop <= early_drop + 1;
        if (start && prev_start && ((a != prev_a) || (b != prev_b))) ab_viol <= ab_viol + 1;
        prev_start <= start;
        prev_ack   <= ack;
        prev_a     <= a;
        prev_b     <= b;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    logic keep_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] pa, input logic [W-1:0] pb);
        int n;
        n = 0;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_wait_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = pa;
        in_b     = pb;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        int n;
        n = 0;
        while (!res_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) check({tag, "_wait_valid"}, 32'(res_valid), 32'd1);
    endtask

    task automatic get_result(input string tag, input logic [W-1:0] exp_d, input logic exp_e);
        wait_res(tag);
        check({tag, "_data"}, 32'(res_data), 32'(exp_d));
        check({tag, "_err"},  32'(res_err),  32'(exp_e));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = keep_ready;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!start && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!start) check({tag, "_wait_start"}, 32'(start), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int r0;
        int n;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        res_ready  = 1'b0;
        keep_ready = 1'b0;
        resp_en    = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_start",     32'(start),     32'd0);
        check("rst_a",         32'(a),         32'd0);
        check("rst_b",         32'(b),         32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_err",   32'(res_err),   32'd0);
        check("rst_res_data",  32'(res_data),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_busy",      32'(busy),      32'd0);

        // Single pair through the handshake
        r0 = rises;
        push(8'd10, 8'd24);
        get_result("p10_24", 8'd2, 1'b0);
        check("p10_24_one_start", 32'(rises - r0), 32'd1);
        check("p10_24_rise_a",    32'(rise_a),     32'd10);
        check("p10_24_rise_b",    32'(rise_b),     32'd24);

        // Back-to-back pairs with downstream always ready
        keep_ready = 1'b1;
        res_ready  = 1'b1;
        r0 = rises;
        push(8'd10, 8'd24);
        push(8'd11, 8'd33);
        push(8'd9,  8'd6);
        get_result("b2b_0", 8'd2,  1'b0);
        get_result("b2b_1", 8'd11, 1'b0);
        get_result("b2b_2", 8'd3,  1'b0);
        check("b2b_starts", 32'(rises - r0), 32'd3);
        keep_ready = 1'b0;
        res_ready  = 1'b0;
        repeat (4) @(negedge clk);

        // Zero operands answered locally
        r0 = rises;
        push(8'd0, 8'd7);
        get_result("triv_0_7", 8'd7, 1'b0);
        push(8'd0, 8'd0);
        get_result("triv_0_0", 8'd0, 1'b0);
        push(8'd5, 8'd0);
        get_result("triv_5_0", 8'd5, 1'b0);
        check("triv_no_start", 32'(rises - r0), 32'd0);

        // Fill the queue while downstream stalls
        push(8'd12, 8'd18);
        push(8'd14, 8'd21);
        push(8'd15, 8'd25);
        push(8'd16, 8'd40);
        push(8'd27, 8'd36);
        check("fill_in_ready_low", 32'(in_ready), 32'd0);
        repeat (20) @(negedge clk);
        check("hold_valid",    32'(res_valid), 32'd1);
        check("hold_data",     32'(res_data),  32'd6);
        check("hold_in_ready", 32'(in_ready),  32'd0);
        check("hold_busy",     32'(busy),      32'd1);
        repeat (7) @(negedge clk);
        check("hold_data_2",   32'(res_data),  32'd6);
        check("hold_start",    32'(start),     32'd0);
        get_result("fill_0", 8'd6, 1'b0);
        get_result("fill_1", 8'd7, 1'b0);
        get_result("fill_2", 8'd5, 1'b0);
        get_result("fill_3", 8'd8, 1'b0);
        get_result("fill_4", 8'd9, 1'b0);
        repeat (4) @(negedge clk);
        check("drain_busy",     32'(busy),     32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);

        check("early_drop", 32'(early_drop), 32'd0);

        // Responder never acks: abort after TIMEOUT+1 cycles
        resp_en = 1'b0;
        push(8'd8, 8'd12);
        wait_start("tmo");
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", 32'(n),        32'd16);
        check("tmo_start",  32'(start),    32'd0);
        get_result("tmo", 8'd0, 1'b1);
        resp_en = 1'b1;
        push(8'd21, 8'd14);
        get_result("after_tmo", 8'd7, 1'b0);

        // Reset in the middle of a request
        resp_en = 1'b0;
        push(8'd9, 8'd6);
        push(8'd4, 8'd6);
        wait_start("rstreq");
        check("rstreq_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstreq_start",     32'(start),     32'd0);
        check("rstreq_res_valid", 32'(res_valid), 32'd0);
        check("rstreq_busy",      32'(busy),      32'd0);
        check("rstreq_in_ready",  32'(in_ready),  32'd1);
        rst     = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        push(8'd9, 8'd6);
        get_result("after_rst", 8'd3, 1'b0);
        repeat (4) @(negedge clk);
        check("after_rst_idle", 32'(busy), 32'd0);

        check("stale_ack_start", 32'(stale_viol), 32'd0);
        check("ab_stable",       32'(ab_viol),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
